// File: rtl/serial_pkg.sv
// Shared definitions for the programmer's serial link: transmitter FSM states,
// frame geometry and the default bit-rate divider also used by the receiver.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int DATA_BITS      = 8;
    localparam int DIV_460800_12M = 26;   // 12 MHz / 26 ~= 460800 baud
    localparam int TIMER_W        = 16;
    localparam int BIT_IDX_W      = 3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO: dout always shows the head entry,
// and a push while full is dropped even when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic             r_full;

    logic             w_push;
    logic             w_pop;
    logic [AW-1:0]    w_wr_ptr_inc;
    logic [AW-1:0]    w_rd_ptr_inc;

    // Equal pointers mean empty unless the full flag says the writer lapped the reader.
    assign empty        = !r_full && (r_wr_ptr == r_rd_ptr);
    assign full         = r_full;
    assign w_push       = push && !r_full;
    assign w_pop        = pop && !empty;
    assign w_wr_ptr_inc = r_wr_ptr + AW'(1);
    assign w_rd_ptr_inc = r_rd_ptr + AW'(1);
    assign dout         = r_mem[r_rd_ptr];
    assign count        = {r_full, r_wr_ptr - r_rd_ptr};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= w_wr_ptr_inc;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_inc;
            end
            if (w_push && !w_pop && (w_wr_ptr_inc == r_rd_ptr)) begin
                r_full <= 1'b1;
            end else if (w_pop && !w_push) begin
                r_full <= 1'b0;
            end
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers alone
    // define which entries are valid, and an unreset array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/serial_tx.sv
// Byte-wide 8N1 UART transmitter with a small FIFO; frames go out LSB first
// on a registered tx line, back-to-back with a single stop bit between bytes.
module serial_tx
    import serial_pkg::*;
#(
    parameter int CLK_DIV    = DIV_460800_12M,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_BITS-1:0]        tx_byte,
    input  logic                        tx_valid,
    output logic                        tx_full,
    output logic                        tx_busy,
    output logic                        tx_overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        tx
);

    localparam logic [TIMER_W-1:0]   BIT_LAST  = TIMER_W'(CLK_DIV - 1);
    localparam logic [BIT_IDX_W-1:0] LAST_DATA = BIT_IDX_W'(DATA_BITS - 1);

    tx_state_t                   r_state;
    tx_state_t                   w_state_nxt;
    logic [TIMER_W-1:0]          r_timer;
    logic [TIMER_W-1:0]          w_timer_nxt;
    logic [BIT_IDX_W-1:0]        r_bit_idx;
    logic [BIT_IDX_W-1:0]        w_bit_idx_nxt;
    logic [DATA_BITS-1:0]        r_sh;
    logic [DATA_BITS-1:0]        w_sh_nxt;
    logic                        r_tx;
    logic                        w_tx_nxt;
    logic                        r_overflow;

    logic                        w_pop;
    logic                        w_timer_done;
    logic                        w_fifo_empty;
    logic                        w_fifo_full;
    logic [DATA_BITS-1:0]        w_fifo_dout;
    logic [$clog2(FIFO_DEPTH):0] w_fifo_count;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_valid),
        .pop   (w_pop),
        .din   (tx_byte),
        .dout  (w_fifo_dout),
        .count (w_fifo_count),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    assign w_timer_done = (r_timer == '0);

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_bit_idx_nxt = r_bit_idx;
        w_sh_nxt      = r_sh;
        w_pop         = 1'b0;
        w_tx_nxt      = 1'b1;

        unique case (r_state)
            IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_sh_nxt    = w_fifo_dout;
                    w_timer_nxt = BIT_LAST;
                    w_state_nxt = START;
                end
            end
            START: begin
                if (w_timer_done) begin
                    w_timer_nxt   = BIT_LAST;
                    w_bit_idx_nxt = '0;
                    w_state_nxt   = DATA;
                end else begin
                    w_timer_nxt = r_timer - TIMER_W'(1);
                end
            end
            DATA: begin
                if (w_timer_done) begin
                    w_timer_nxt   = BIT_LAST;
                    w_sh_nxt      = r_sh >> 1;
                    w_bit_idx_nxt = r_bit_idx + BIT_IDX_W'(1);
                    if (r_bit_idx == LAST_DATA) begin
                        w_state_nxt = STOP;
                    end
                end else begin
                    w_timer_nxt = r_timer - TIMER_W'(1);
                end
            end
            STOP: begin
                if (w_timer_done) begin
                    // Chain straight into the next start bit when more data waits.
                    if (!w_fifo_empty) begin
                        w_pop       = 1'b1;
                        w_sh_nxt    = w_fifo_dout;
                        w_timer_nxt = BIT_LAST;
                        w_state_nxt = START;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_timer_nxt = r_timer - TIMER_W'(1);
                end
            end
        endcase

        // The line level is derived from the state being entered, so tx is a
        // pure register with no combinational path from the inputs.
        case (w_state_nxt)
            START:   w_tx_nxt = 1'b0;
            DATA:    w_tx_nxt = w_sh_nxt[0];
            default: w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_timer    <= '0;
            r_bit_idx  <= '0;
            r_sh       <= '0;
            r_tx       <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_sh       <= w_sh_nxt;
            r_tx       <= w_tx_nxt;
            r_overflow <= r_overflow | (tx_valid & w_fifo_full);
        end
    end

    assign tx          = r_tx;
    assign tx_full     = w_fifo_full;
    assign fifo_count  = w_fifo_count;
    assign tx_overflow = r_overflow;
    assign tx_busy     = (r_state != IDLE) || (w_fifo_count != '0);

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: a CLK_DIV=4 instance for framing and FIFO
// behaviour, and a default-rate instance for the overflow scenario.
module tb_serial_tx;

    logic       clk = 1'b0;
    logic       reset;

    logic [7:0] f_byte;
    logic       f_valid;
    logic       f_full, f_busy, f_ovf, f_tx;
    logic [4:0] f_count;

    logic [7:0] s_byte;
    logic       s_valid;
    logic       s_full, s_busy, s_ovf, s_tx;
    logic [4:0] s_count;

    logic [7:0] exp_bytes [0:31];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_tx #(.CLK_DIV(4), .FIFO_DEPTH(16)) dut_fast (
        .clk         (clk),
        .reset       (reset),
        .tx_byte     (f_byte),
        .tx_valid    (f_valid),
        .tx_full     (f_full),
        .tx_busy     (f_busy),
        .tx_overflow (f_ovf),
        .fifo_count  (f_count),
        .tx          (f_tx)
    );

    serial_tx #(.CLK_DIV(26), .FIFO_DEPTH(16)) dut_slow (
        .clk         (clk),
        .reset       (reset),
        .tx_byte     (s_byte),
        .tx_valid    (s_valid),
        .tx_full     (s_full),
        .tx_busy     (s_busy),
        .tx_overflow (s_ovf),
        .fifo_count  (s_count),
        .tx          (s_tx)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected line level in bit slot seg (0 = start, 1..8 = data LSB first, 9 = stop).
    function automatic logic exp_bit(input logic [7:0] b, input int seg);
        if (seg == 0)
            return 1'b0;
        else if (seg <= 8)
            return b[seg-1];
        else
            return 1'b1;
    endfunction

    // Samples n consecutive frames cycle by cycle; k0 is the cycle offset within
    // the first frame that the current sample corresponds to.
    task automatic run_frames(input bit slow, input int div, input int n, input int k0, input string tag);
        int         bad;
        logic [7:0] got;
        logic       line;
        for (int f = 0; f < n; f++) begin
            bad = 0;
            got = '0;
            for (int k = (f == 0) ? k0 : 0; k < 10 * div; k++) begin
                if (!(f == 0 && k == k0)) tick();
                line = slow ? s_tx : f_tx;
                if (line !== exp_bit(exp_bytes[f], k / div)) bad++;
                if ((k % div == div / 2) && (k / div >= 1) && (k / div <= 8))
                    got[k / div - 1] = line;
            end
            check($sformatf("%s frame%0d bad_cycles", tag, f), bad, 0);
            check($sformatf("%s frame%0d byte", tag, f), got, exp_bytes[f]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int lows;

        reset   = 1'b1;
        f_valid = 1'b0;
        f_byte  = '0;
        s_valid = 1'b0;
        s_byte  = '0;

        // Reset values, then a quiet line after release.
        repeat (3) tick();
        check("rst tx",       f_tx,    1);
        check("rst count",    f_count, 0);
        check("rst busy",     f_busy,  0);
        check("rst overflow", f_ovf,   0);
        check("rst full",     f_full,  0);
        check("rst slow tx",  s_tx,    1);
        reset = 1'b0;
        lows = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (f_tx !== 1'b1) lows++;
        end
        check("idle line lows", lows, 0);
        check("idle busy", f_busy, 0);

        // Single byte 0x55: start one edge after the push, busy drops at N+41.
        f_valid = 1'b1;
        f_byte  = 8'h55;
        tick();
        f_valid = 1'b0;
        check("single count after push", f_count, 1);
        check("single tx before pop",    f_tx,    1);
        check("single busy after push",  f_busy,  1);
        tick();
        check("single count after pop",  f_count, 0);
        exp_bytes[0] = 8'h55;
        run_frames(1'b0, 4, 1, 0, "single");
        check("single busy at N+40", f_busy, 1);
        tick();
        check("single busy at N+41", f_busy, 0);
        check("single tx idle",      f_tx,   1);

        // Back-to-back 0xA5, 0x3C: the second push coincides with the first pop.
        f_valid = 1'b1;
        f_byte  = 8'hA5;
        tick();
        f_byte  = 8'h3C;
        tick();
        f_valid = 1'b0;
        check("b2b count push+pop", f_count, 1);
        exp_bytes[0] = 8'hA5;
        exp_bytes[1] = 8'h3C;
        run_frames(1'b0, 4, 2, 0, "b2b");
        tick();
        check("b2b busy done", f_busy, 0);

        // Push coincident with the STOP->START pop at count 3.
        f_valid = 1'b1;
        f_byte  = 8'h11;
        tick();
        f_byte  = 8'h22;
        tick();
        f_byte  = 8'h33;
        tick();
        f_byte  = 8'h44;
        tick();
        f_valid = 1'b0;
        check("pp count before", f_count, 3);
        repeat (37) tick();
        f_valid = 1'b1;
        f_byte  = 8'h96;
        tick();
        f_valid = 1'b0;
        check("pp count same cycle", f_count, 3);
        check("pp new start bit",    f_tx,    0);
        exp_bytes[0] = 8'h22;
        exp_bytes[1] = 8'h33;
        exp_bytes[2] = 8'h44;
        exp_bytes[3] = 8'h96;
        run_frames(1'b0, 4, 4, 0, "pp");
        tick();
        check("pp busy done",  f_busy,  0);
        check("pp count done", f_count, 0);

        // Reset during data bit 3 of 0xF0 with five bytes queued.
        f_valid = 1'b1;
        f_byte  = 8'hF0;
        tick();
        for (int i = 0; i < 5; i++) begin
            f_byte = 8'hC0 + 8'(i);
            tick();
        end
        f_valid = 1'b0;
        repeat (13) tick();
        check("midrst bit3 level", f_tx,    0);
        check("midrst queued",     f_count, 5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst tx",       f_tx,    1);
        check("midrst count",    f_count, 0);
        check("midrst busy",     f_busy,  0);
        check("midrst full",     f_full,  0);
        check("midrst overflow", f_ovf,   0);
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (f_tx !== 1'b1) lows++;
        end
        check("midrst no resume lows", lows, 0);
        check("midrst busy after",     f_busy, 0);

        // Overflow at the default rate: 18 pushes, 0x11 dropped.
        for (int i = 0; i < 18; i++) begin
            s_valid = 1'b1;
            s_byte  = 8'(i);
            tick();
            if (i == 16) begin
                check("ovf full at 17",     s_full,  1);
                check("ovf sticky at 17",   s_ovf,   0);
                check("ovf count at 17",    s_count, 16);
            end
        end
        s_valid = 1'b0;
        check("ovf full at 18",   s_full,  1);
        check("ovf sticky at 18", s_ovf,   1);
        check("ovf count at 18",  s_count, 16);
        for (int i = 0; i < 17; i++) exp_bytes[i] = 8'(i);
        run_frames(1'b1, 26, 17, 16, "ovf");
        tick();
        check("ovf busy done",     s_busy, 0);
        check("ovf sticky held",   s_ovf,  1);
        check("ovf full cleared",  s_full, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
